// File: rtl/sseg_disp_ctrl.sv
// rtl/sseg_disp_ctrl.sv - 4-digit 7-segment display controller (score BCD, message overlay, refresh strobe)
//
// Converts a binary score to BCD with a sequential double-dabble engine, applies
// leading-zero blanking, and lets a timed message override the score display.
// Also generates the refresh strobe that paces the digit multiplexer.
//
// Ports:
//   clk          - posedge clock
//   rst          - synchronous active-high reset
//   score        - binary score, sampled when score_valid=1
//   score_valid  - one-cycle strobe requesting a score conversion
//   msg_req      - one-cycle strobe: show msg_bcd for MSG_TICKS refresh ticks
//   msg_bcd      - message digits {d3,d2,d1,d0}; 4'hF = blank
//   blank_lz     - 1 = blank leading zeros of the score
//   bcd0..bcd3   - registered digit codes (bcd0 = rightmost)
//   refresh_tick - one-cycle strobe every REFRESH_DIV cycles
//   busy         - conversion engine not idle
//   msg_active   - message currently selected for display

module sseg_disp_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int MSG_TICKS   = 2000,
    parameter int SCORE_W     = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    input  logic               msg_req,
    input  logic [15:0]        msg_bcd,
    input  logic               blank_lz,
    output logic [3:0]         bcd0,
    output logic [3:0]         bcd1,
    output logic [3:0]         bcd2,
    output logic [3:0]         bcd3,
    output logic               refresh_tick,
    output logic               busy,
    output logic               msg_active
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TMR_W = $clog2(MSG_TICKS + 1);
    localparam int CNT_W = $clog2(SCORE_W + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   BIT_LAST = CNT_W'(SCORE_W - 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(MSG_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(9999);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    // ------------------------------------------------------------------
    // Refresh divider (free running)
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign refresh_tick = (div_cnt == DIV_LAST);

    // ------------------------------------------------------------------
    // Request capture: every request goes through the one-deep pending
    // register, so a request arriving mid-conversion simply overwrites it
    // and is picked up when the engine returns to IDLE.
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic               pend;
    logic [SCORE_W-1:0] pend_score;
    logic [SCORE_W-1:0] score_sat;

    assign score_sat = (32'(score) > 32'd9999) ? SCORE_SAT : score;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            pend_score <= '0;
        end else if (score_valid) begin
            pend       <= 1'b1;
            pend_score <= score_sat;
        end else if (state_q == S_IDLE && pend) begin
            pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   bit_cnt;
    logic [SCORE_W-1:0] shift_reg;
    logic [15:0]        acc;
    logic [14:0]        acc_adj;
    logic [15:0]        score_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pend) state_d = S_SHIFT;
            S_SHIFT:  if (bit_cnt == BIT_LAST) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // Add-3 correction ahead of the shift. The top nibble keeps only its
    // low three bits: its MSB is shifted out and can only be set for values
    // above 9999, which saturation rules out.
    always_comb begin
        acc_adj = '0;
        for (int k = 0; k < 3; k++) begin
            acc_adj[4*k +: 4] = (acc[4*k +: 4] >= 4'd5) ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
        end
        acc_adj[14:12] = (acc[15:12] >= 4'd5) ? 3'(acc[15:12] + 4'd3) : acc[14:12];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            acc       <= '0;
            score_bcd <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend) begin
                        shift_reg <= pend_score;
                        acc       <= '0;
                        bit_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    acc       <= {acc_adj, shift_reg[SCORE_W-1]};
                    shift_reg <= {shift_reg[SCORE_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                end
                S_COMMIT: begin
                    score_bcd <= acc;
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Message overlay
    // ------------------------------------------------------------------
    logic [15:0]      msg_digits;
    logic [TMR_W-1:0] msg_timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_digits <= 16'hFFFF;
            msg_timer  <= '0;
            msg_active <= 1'b0;
        end else if (msg_req) begin
            // A new request wins over the final tick of a running message.
            msg_digits <= msg_bcd;
            msg_timer  <= TMR_LOAD;
            msg_active <= 1'b1;
        end else if (msg_active && refresh_tick) begin
            msg_timer <= msg_timer - TMR_W'(1);
            if (msg_timer == TMR_W'(1)) begin
                msg_active <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking and output register
    // ------------------------------------------------------------------
    logic [15:0] score_disp;
    logic [15:0] disp_q;

    always_comb begin
        score_disp = score_bcd;
        if (blank_lz && score_bcd[15:12] == 4'd0) begin
            score_disp[15:12] = 4'hF;
            if (score_bcd[11:8] == 4'd0) begin
                score_disp[11:8] = 4'hF;
                if (score_bcd[7:4] == 4'd0) begin
                    score_disp[7:4] = 4'hF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= {(blank_lz ? 12'hFFF : 12'h000), 4'h0};
        end else if (msg_active) begin
            disp_q <= msg_digits;
        end else begin
            disp_q <= score_disp;
        end
    end

    assign bcd3 = disp_q[15:12];
    assign bcd2 = disp_q[11:8];
    assign bcd1 = disp_q[7:4];
    assign bcd0 = disp_q[3:0];

endmodule

// File: doc/sseg_disp_ctrl.md
Name: sseg_disp_ctrl

Overview:
- Display controller in front of the 4-digit 7-segment multiplexer. Produces the four BCD digit codes the multiplexer consumes.
- Converts a binary game score to BCD with a sequential double-dabble engine and applies leading-zero blanking.
- Arbitrates the display between the score and a timed message: message has priority while its timer runs.
- Generates the refresh strobe that paces digit multiplexing.

Parameters:
- REFRESH_DIV, 100000, clk cycles per refresh_tick (1 kHz at 100 MHz); legal range >= 2.
- MSG_TICKS, 2000, refresh_ticks a message stays on display (2 s at defaults); legal range >= 1.
- SCORE_W, 14, width of binary score input (max representable display 9999).

Ports:
- clk, input, 1, posedge clock, 100 MHz.
- rst, input, 1, reset, synchronous, active-high.
- score, input, SCORE_W, binary score; sampled only when score_valid=1.
- score_valid, input, 1, one-cycle strobe requesting a new score conversion.
- msg_req, input, 1, one-cycle strobe: show msg_bcd for MSG_TICKS refresh ticks.
- msg_bcd, input, 16, message digits {d3,d2,d1,d0}, 4 bits each; 4'hF = blank; sampled on msg_req.
- blank_lz, input, 1, 1 = blank leading zeros of the score (static config).
- bcd0..bcd3, output, 4 each, registered digit codes to the multiplexer (bcd0 = rightmost).
- refresh_tick, output, 1, one-cycle strobe every REFRESH_DIV cycles.
- busy, output, 1, conversion engine not in IDLE.
- msg_active, output, 1, message currently selected for display.

Behaviour:
- Reset (rst=1 at posedge): FSM=IDLE, pending flag=0, score_bcd=0000, message regs=FFFF, msg timer=0, divider=0.
  - Outputs after reset: bcd3..bcd0 = F,F,F,0 if blank_lz=1, else 0,0,0,0; refresh_tick=0, busy=0, msg_active=0.
  - rst mid-conversion aborts the conversion and drops any pending request.
- Refresh divider: counts 0..REFRESH_DIV-1 and wraps. refresh_tick=1 for exactly the cycle the count equals REFRESH_DIV-1. The divider runs unconditionally.
- Conversion FSM:
  - IDLE: on score_valid (or pending=1), load shift reg = min(score, 9999), BCD accumulator = 0, go to SHIFT.
  - SHIFT: for SCORE_W cycles, add 3 to each BCD nibble >= 5, then shift left 1.
  - COMMIT: write the accumulator to score_bcd, return to IDLE.
  - Latency: score_valid at edge N -> score_bcd valid after edge N+SCORE_W+2 -> bcd outputs update at edge N+SCORE_W+3 (17 cycles at default) when the score is selected.
  - busy=1 in SHIFT and COMMIT.
  - Saturation: score > 9999 displays 9999.
- Request while busy: latch score into a one-deep pending register (a later request overwrites it); conversion restarts from pending on the cycle after COMMIT. No requests are lost except overwritten ones.
- Message arbitration:
  - msg_req loads msg_bcd and timer=MSG_TICKS, and sets msg_active=1 from the next cycle.
  - Timer decrements on each refresh_tick; at 0, msg_active clears on the same edge.
  - msg_req while active restarts the timer with the new digits.
  - msg_req and the final timer tick in the same cycle: the request wins.
- Output mux (registered, 1 cycle):
  - msg_active=1: bcd = message digits, passed through unmodified.
  - msg_active=0: bcd = score_bcd with blanking applied.
  - Score conversions continue while a message is shown. The newest score appears when the message ends.
- Leading-zero blanking (score only, blank_lz=1): digit k (k=3..1) becomes 4'hF if it and all higher digits are 0. bcd0 is never blanked.

Test Plan:
- Reset then score=1234, score_valid 1 cycle -> busy for 15 cycles; bcd3..0 = 1,2,3,4 exactly 17 cycles after the strobe.
- blank_lz=1, score=7 -> bcd3..0 = F,F,F,7; score=0 -> F,F,F,0; blank_lz=0, score=0 -> 0,0,0,0.
- score=12000 -> 9,9,9,9; score=16383 -> 9,9,9,9.
- score=5 strobe, then score=42 then score=99 strobes during busy -> display shows 5, then 99; 42 never appears.
- REFRESH_DIV=4, MSG_TICKS=3:
  - msg_req with msg_bcd=16'hFAB0 -> bcd = F,A,B,0 and msg_active=1 for 3 ticks, then reverts to score.
  - msg_req on the final tick -> message extends by 3 ticks.
- rst asserted mid-SHIFT and mid-message -> next cycle busy=0, msg_active=0, bcd = reset pattern; a new score_valid after reset converts normally.
